// File: rtl/pbit_sweep_scheduler_pkg.sv
// Shared definitions for the p-bit Gibbs sweep scheduler: default sizes,
// spin encoding and controller state type.
package pbit_sweep_scheduler_pkg;

  localparam int unsigned PBIT_N_DEF       = 16;
  localparam int unsigned PBIT_SWEEP_W_DEF = 16;
  localparam int unsigned PBIT_TIMEOUT_DEF = 64;

  // Spin encoding on m_state: 1 means +1, 0 means -1.
  localparam logic SPIN_POS = 1'b1;
  localparam logic SPIN_NEG = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pbit_sweep_scheduler_if.sv
// Link between the sweep scheduler and the shared MAC/activation/compare datapath.
interface pbit_sweep_scheduler_if
    import pbit_sweep_scheduler_pkg::*;
#(
    parameter int unsigned N_PBITS = PBIT_N_DEF,
    parameter int unsigned IDX_W   = $clog2(N_PBITS)
);
    logic [N_PBITS-1:0] m_state;
    logic               dp_req;
    logic [IDX_W-1:0]   dp_idx;
    logic               dp_ack;
    logic               dp_bit;

    modport master (output m_state, dp_req, dp_idx, input dp_ack, dp_bit);
    modport slave  (input m_state, dp_req, dp_idx, output dp_ack, dp_bit);
endinterface

// File: rtl/pbit_sweep_scheduler_wait_timer.sv
// Watchdog for the datapath wait: counts enabled cycles after a clear and
// flags the cycle whose increment would reach TIMEOUT-1.
module pbit_wait_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expired = enable && (count_q == 8'(TIMEOUT - 2));
endmodule

// File: rtl/pbit_sweep_scheduler.sv
// Sequential Gibbs sweep controller: visits p-bits in index order, one
// datapath request at a time, committing each new spin before the next issue.
module pbit_sweep_scheduler
    import pbit_sweep_scheduler_pkg::*;
#(
    parameter int unsigned N_PBITS = PBIT_N_DEF,
    parameter int unsigned IDX_W   = $clog2(N_PBITS),
    parameter int unsigned SWEEP_W = PBIT_SWEEP_W_DEF,
    parameter int unsigned TIMEOUT = PBIT_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SWEEP_W-1:0]     num_sweeps,
    input  logic                   abort,
    input  logic                   load_init,
    input  logic [N_PBITS-1:0]     m_init,
    pbit_sweep_scheduler_if.master dp,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic [SWEEP_W-1:0]     sweep_count
);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PBITS - 1);

    sched_state_e       state_q, state_d;
    logic [N_PBITS-1:0] m_q, m_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SWEEP_W-1:0] cnt_q, cnt_d, tgt_q, tgt_d, cnt_inc;
    logic               done_q, done_d;
    logic               terr_q, terr_d;
    logic               tmr_clear, tmr_en, tmr_expired;

    pbit_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q    <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            tgt_q  <= '0;
            done_q <= 1'b0;
            terr_q <= 1'b0;
        end else begin
            m_q    <= m_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            tgt_q  <= tgt_d;
            done_q <= done_d;
            terr_q <= terr_d;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    // Abort outranks an ack in the same cycle, so that ack is never committed.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        done_d    = 1'b0;
        terr_d    = terr_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_init) begin
                    m_d = m_init;
                end
                if (start) begin
                    tgt_d  = num_sweeps;
                    cnt_d  = '0;
                    idx_d  = '0;
                    terr_d = 1'b0;
                    if (num_sweeps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_clear = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (dp.dp_ack) begin
                    m_d[idx_q] = dp.dp_bit;
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        idx_d = '0;
                        cnt_d = cnt_inc;
                        if (cnt_inc == tgt_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        terr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dp.m_state  = m_q;
    assign dp.dp_idx   = idx_q;
    assign dp.dp_req   = (state_q == ST_ISSUE) && !abort;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign sweep_count = cnt_q;
endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Self-checking bench: the bench acts as the datapath and keeps a
// transaction-level model of spins, sweep count, busy and error state.
module tb_pbit_sweep_scheduler;
    localparam int N  = 4;
    localparam int TO = 8;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          load_init = 1'b0;
    logic [SW-1:0] num_sweeps = '0;
    logic [N-1:0]  m_init = '0;
    logic          busy, done, timeout_err;
    logic [SW-1:0] sweep_count;

    pbit_sweep_scheduler_if #(.N_PBITS(N), .IDX_W(2)) dpif ();

    pbit_sweep_scheduler #(.N_PBITS(N), .IDX_W(2), .SWEEP_W(SW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_sweeps  (num_sweeps),
        .abort       (abort),
        .load_init   (load_init),
        .m_init      (m_init),
        .dp          (dpif),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .sweep_count (sweep_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [N-1:0] exp_m = '0;
    int           exp_cnt = 0;
    bit           exp_terr = 1'b0;
    bit           exp_busy = 1'b0;
    int           exp_idx = 0;
    int           req_seen = 0;
    int           done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_state", 32'(dpif.m_state), 32'(exp_m));
            chk("sweep_count", 32'(sweep_count), 32'(exp_cnt));
            chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_busy) chk("dp_idx", 32'(dpif.dp_idx), 32'(exp_idx));
            if (done) begin
                done_seen++;
                chk("done_while_busy", 32'(busy), 32'd0);
            end
            if (dpif.dp_req) req_seen++;
        end
    end

    // bit_mode: 0 = always +1, 1 = flip current spin, 2 = random.
    task automatic run(input int nsw, input bit do_load, input logic [N-1:0] init,
                       input int lat_min, input int lat_max, input int bit_mode,
                       input int abort_sweep, input int abort_idx);
        int   done_before;
        int   req_before;
        int   lat;
        logic b;
        done_before = done_seen;
        req_before  = req_seen;
        start = 1'b1; num_sweeps = SW'(nsw); load_init = do_load; m_init = init;
        cyc();
        start = 1'b0; load_init = 1'b0;
        if (do_load) exp_m = init;
        exp_cnt = 0; exp_terr = 1'b0; exp_idx = 0; exp_busy = (nsw != 0);
        if (nsw == 0) begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_req", 32'(dpif.dp_req), 32'd0);
            cyc();
            chk("zero_done_drop", 32'(done), 32'd0);
            chk("zero_busy", 32'(busy), 32'd0);
            chk("zero_req_count", 32'(req_seen - req_before), 32'd0);
            chk("zero_done_count", 32'(done_seen - done_before), 32'd1);
            return;
        end
        for (int s = 0; s < nsw; s++) begin
            for (int i = 0; i < N; i++) begin
                chk("dp_req_issue", 32'(dpif.dp_req), 32'd1);
                chk("dp_idx_issue", 32'(dpif.dp_idx), 32'(i));
                lat = int'($urandom_range(lat_max, lat_min));
                if (s == 0 && i == 1) begin
                    start = 1'b1; load_init = 1'b1; m_init = ~exp_m; num_sweeps = '0;
                end
                cyc();
                start = 1'b0; load_init = 1'b0; num_sweeps = SW'(nsw);
                for (int k = 1; k < lat; k++) begin
                    chk("dp_req_wait", 32'(dpif.dp_req), 32'd0);
                    cyc();
                end
                case (bit_mode)
                    0:       b = 1'b1;
                    1:       b = ~exp_m[i];
                    default: b = 1'($urandom_range(1, 0));
                endcase
                dpif.dp_ack = 1'b1; dpif.dp_bit = b;
                if (s == abort_sweep && i == abort_idx) begin
                    abort = 1'b1;
                    cyc();
                    abort = 1'b0; dpif.dp_ack = 1'b0;
                    exp_busy = 1'b0;
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_done", 32'(done), 32'd0);
                    cyc();
                    chk("abort_req", 32'(dpif.dp_req), 32'd0);
                    chk("abort_done_count", 32'(done_seen - done_before), 32'd0);
                    return;
                end
                cyc();
                dpif.dp_ack = 1'b0;
                exp_m[i] = b;
                exp_idx = (i + 1) % N;
                if (i == N - 1) exp_cnt++;
            end
        end
        exp_busy = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        cyc();
        chk("done_single", 32'(done), 32'd0);
        chk("req_count", 32'(req_seen - req_before), 32'(nsw * N));
        chk("done_count", 32'(done_seen - done_before), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_before;
        dpif.dp_ack = 1'b0;
        dpif.dp_bit = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(dpif.dp_req), 32'd0);
        chk("rst_m", 32'(dpif.m_state), 32'd0);
        chk("rst_cnt", 32'(sweep_count), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_idx", 32'(dpif.dp_idx), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Basic single sweep, ack one cycle after each request, all spins +1.
        run(1, 1'b1, 4'b0000, 1, 1, 0, -1, -1);
        chk("basic_m", 32'(dpif.m_state), 32'h0000_000f);
        chk("basic_cnt", 32'(sweep_count), 32'd1);

        // Three sweeps flipping every spin: odd flips invert the initial vector.
        run(3, 1'b1, 4'b0110, 3, 3, 1, -1, -1);
        chk("multi_m", 32'(dpif.m_state), 32'h0000_0009);
        chk("multi_cnt", 32'(sweep_count), 32'd3);

        run(0, 1'b0, 4'b0000, 1, 1, 0, -1, -1);

        // Timeout: no ack ever; error visible TO cycles after the ISSUE cycle.
        done_before = done_seen;
        start = 1'b1; num_sweeps = 16'd1;
        cyc();
        start = 1'b0;
        exp_busy = 1'b1; exp_cnt = 0; exp_idx = 0; exp_terr = 1'b0;
        for (int k = 1; k < TO; k++) begin
            cyc();
            chk("to_pending", 32'(timeout_err), 32'd0);
        end
        cyc();
        exp_terr = 1'b1; exp_busy = 1'b0;
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_no_done", 32'(done_seen - done_before), 32'd0);
        run(0, 1'b0, 4'b0000, 1, 1, 0, -1, -1);
        chk("to_cleared", 32'(timeout_err), 32'd0);

        // Abort in WAIT of idx 2 with a coincident ack; start/load_init mid-run ignored.
        run(2, 1'b1, 4'b0000, 1, 2, 0, 0, 2);
        chk("abort_m", 32'(dpif.m_state), 32'h0000_0003);
        chk("abort_cnt", 32'(sweep_count), 32'd0);

        // Abort during ISSUE suppresses the request.
        start = 1'b1; num_sweeps = 16'd1;
        cyc();
        start = 1'b0; abort = 1'b1;
        exp_busy = 1'b1; exp_cnt = 0; exp_idx = 0;
        #1;
        chk("abort_issue_req", 32'(dpif.dp_req), 32'd0);
        cyc();
        abort = 1'b0; exp_busy = 1'b0;
        chk("abort_issue_busy", 32'(busy), 32'd0);

        for (int r = 0; r < 20; r++) begin
            run(int'($urandom_range(3, 1)), 1'($urandom_range(1, 0)), 4'($urandom),
                1, 4, 2, -1, -1);
        end

        // Asynchronous reset mid-WAIT, between clock edges.
        start = 1'b1; num_sweeps = 16'd2; load_init = 1'b1; m_init = 4'b1010;
        cyc();
        start = 1'b0; load_init = 1'b0;
        exp_m = 4'b1010; exp_busy = 1'b1; exp_cnt = 0; exp_idx = 0; exp_terr = 1'b0;
        cyc();
        #3 rst_n = 1'b0;
        #1;
        exp_m = '0; exp_busy = 1'b0; exp_cnt = 0; exp_idx = 0; exp_terr = 1'b0;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_req", 32'(dpif.dp_req), 32'd0);
        chk("arst_m", 32'(dpif.m_state), 32'd0);
        chk("arst_idx", 32'(dpif.dp_idx), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        #12 rst_n = 1'b1;
        cyc();
        chk("arst_idle", 32'(busy), 32'd0);
        run(1, 1'b1, 4'b0101, 1, 2, 2, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pbit_sweep_scheduler.md
Name: pbit_sweep_scheduler

Overview:
- Sequential Gibbs-sweep controller for the p-bit array.
- Owns the spin vector m and, for each sweep, visits p-bits 0..N_PBITS-1 in order. For each one it issues a request to the shared MAC/beta/compare datapath (J*m+h, activation, random compare), waits for the new spin, and commits it before issuing the next index.
- Repeats for a programmed number of sweeps, then pulses done.
- Sits between the host/control interface and the single shared update datapath.

Parameters:
- N_PBITS, 16, number of p-bits; index range 0..N_PBITS-1.
- IDX_W, $clog2(N_PBITS), width of p-bit index.
- SWEEP_W, 16, width of sweep counter and num_sweeps.
- TIMEOUT, 64, max cycles in WAIT before error abort; range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begin run of num_sweeps sweeps; sampled only in IDLE.
- num_sweeps  in  SWEEP_W  sweeps per run; sampled on accepted start.
- abort  in  1  level/pulse; terminate run.
- load_init  in  1  load m_init into spin vector; IDLE only.
- m_init  in  N_PBITS  initial spins (1 = +1, 0 = -1).
- m_state  out  N_PBITS  current spin vector, fed to datapath m_in.
- dp_req  out  1  one-cycle request to datapath.
- dp_idx  out  IDX_W  p-bit index under update; stable from ISSUE until commit.
- dp_ack  in  1  datapath result valid.
- dp_bit  in  1  new spin for dp_idx, valid with dp_ack.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at normal completion.
- timeout_err  out  1  sticky; set on WAIT timeout; cleared by accepted start.
- sweep_count  out  SWEEP_W  completed sweeps in current/last run.

Behaviour:
- Reset (async, rst_n=0): state IDLE; m_state=0; dp_req=0; dp_idx=0; busy=0; done=0; timeout_err=0; sweep_count=0; internal target/timer=0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - load_init=1 → m_state<=m_init next edge.
  - start=1 → latch num_sweeps, sweep_count<=0, dp_idx<=0, timeout_err<=0.
    - If num_sweeps==0: done pulses next cycle, stay IDLE, no dp_req.
    - Otherwise → ISSUE.
  - start and load_init in the same cycle: both take effect; the run uses m_init.
- ISSUE: dp_req=1 for exactly this cycle; timer<=0; → WAIT. dp_ack in ISSUE is ignored.
- WAIT:
  - On dp_ack: m_state[dp_idx]<=dp_bit (commit), then:
    - If dp_idx<N_PBITS-1: dp_idx+1 → ISSUE.
    - Else: dp_idx<=0, sweep_count+1. If sweep_count+1==target: done pulse next cycle, → IDLE. Otherwise → ISSUE.
  - No dp_ack: timer+1. If timer reaches TIMEOUT-1 without ack: timeout_err<=1, → IDLE, no done, no commit.
- Throughput: minimum 2 cycles per p-bit (ISSUE + 1-cycle WAIT); one sweep ≥ 2*N_PBITS cycles.
- Ordering: the commit of index i is visible on m_state before dp_req for i+1 (strict sequential Gibbs).
- abort (any non-IDLE state): → IDLE next edge; dp_req=0 that cycle. Already committed bits are kept; an ack arriving in the abort cycle is discarded. No done. sweep_count holds its value. abort in IDLE has no effect.
- start while busy: ignored. load_init while busy: ignored.
- sweep_count wraps naturally only if target wraps; run length is exactly num_sweeps.
- done and busy: done asserts in the first IDLE cycle (busy=0).

Decomposition:
- Shared package/header: state encoding constants (IDLE/ISSUE/WAIT), spin encoding (1=+1), default N_PBITS/SWEEP_W, tied to the existing p-bit width macros so that N_PBITS matches the J array length.
- One natural sub-module: pbit_wait_timer (clear, enable, expire at TIMEOUT-1) to isolate the watchdog.
- Everything else is inline FSM + counters.

Test Plan:
- Basic run:
  - Stimulus: N_PBITS=4; load_init m_init=4'b0000; start num_sweeps=1; datapath acks 1 cycle after each dp_req with dp_bit=1.
  - Response: dp_idx sequence 0,1,2,3; m_state reaches 4'b1111; done one pulse 8 cycles after the first ISSUE; sweep_count=1.
- Multiple sweeps:
  - Stimulus: num_sweeps=3; ack latency 3; dp_bit = ~m_state[idx].
  - Response: 12 requests; done once; final m_state = ~initial (odd flips); sweep_count=3.
- Zero sweeps:
  - Stimulus: start with num_sweeps=0.
  - Response: no dp_req; done pulses next cycle; busy stays 0.
- Timeout:
  - Stimulus: TIMEOUT=8; never ack.
  - Response: timeout_err=1 eight cycles after ISSUE; state IDLE; no done; m_state unchanged.
  - Then start again → timeout_err clears.
- Abort:
  - Stimulus: abort in WAIT of idx 2 during sweep 0, with dp_ack in the same cycle.
  - Response: bit 2 not committed; bits 0-1 committed; busy=0 next cycle; no done; start/load_init during the run ignored.
- Async reset:
  - Stimulus: assert rst_n=0 mid-WAIT, without a clock edge.
  - Response: all outputs go to reset values immediately; IDLE after release.
